seg_scan_capture: RTL and testbench

- Receive-side counterpart of the 8-digit 7-segment scan driver.
- Watches the multiplexed digit-select (led_en) and segment (led_cx) lines and rebuilds the 64-bit display frame that the driver is scanning out.
- Raises a one-cycle strobe each time a complete frame has been collected, and flags illegal select patterns and a stalled scan.
- Used as an on-board self-check / loopback monitor beside the display controller, and as the bench's scoreboard front end.

---
 rtl/seg_scan_capture.sv | 174 +++++++++++++++++
 tb/tb_seg_scan_capture.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_capture.sv
// seg_scan_capture
//   Receive-side monitor for an 8-digit multiplexed 7-segment scan. It watches
//   the active-low digit select and segment lines, samples each digit once its
//   select has been stable long enough, and rebuilds the 64-bit display frame.
//
// Ports
//   clk            system clock
//   rst            synchronous reset, active-high
//   led_en[7:0]    digit select, active-low one-hot (bit i low = digit i)
//   led_cx[7:0]    segment byte of the selected digit, active-low, kept raw
//   err_clr        pulse that clears scan_err
//   frame[63:0]    last complete frame, digit i at [8i+7:8i]
//   frame_valid    one-cycle pulse, frame updated in the same cycle
//   capture_strobe one-cycle pulse per digit sampled
//   capture_idx    index of the digit sampled, valid with capture_strobe
//   scan_err       sticky flag: select was neither one-hot-low nor 8'hFF
//   stale          no frame completed within STALE_CYCLES cycles
module seg_scan_capture #(
  parameter int SETTLE_CYCLES = 16,
  parameter int STALE_CYCLES  = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  led_en,
  input  logic [7:0]  led_cx,
  input  logic        err_clr,
  output logic [63:0] frame,
  output logic        frame_valid,
  output logic        capture_strobe,
  output logic [2:0]  capture_idx,
  output logic        scan_err,
  output logic        stale
);

  localparam int DW = $clog2(SETTLE_CYCLES + 1);
  localparam int SW = $clog2(STALE_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_HELD
  } state_t;

  state_t        state_reg, state_next;
  logic [DW-1:0] d_reg, d_next;
  logic [SW-1:0] s_reg;
  logic [7:0]    en_q_reg, cx_q_reg, en_prev_reg;
  logic [7:0]    mask_reg;
  logic [63:0]   shadow_reg;
  logic [63:0]   frame_reg;
  logic          frame_valid_reg;
  logic          capture_strobe_reg;
  logic [2:0]    capture_idx_reg;
  logic          scan_err_reg;

  // Select decode on the registered copy of led_en.
  logic [7:0]  sel_n;
  logic        one_hot;
  logic        blank;
  logic        illegal;
  logic        changed;
  logic [2:0]  sel_idx;
  logic        fire;
  logic [7:0]  mask_merged;
  logic [63:0] shadow_merged;
  logic        frame_done;

  assign sel_n   = ~en_q_reg;
  assign one_hot = (sel_n != 8'h00) && ((sel_n & (sel_n - 8'd1)) == 8'h00);
  assign blank   = (en_q_reg == 8'hFF);
  assign illegal = !one_hot && !blank;
  assign changed = (en_q_reg != en_prev_reg);

  always_comb begin
    sel_idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (!en_q_reg[i]) sel_idx = 3'(i);
    end
  end

  // Dwell state machine. Any non-one-hot select (blank or illegal) ends the
  // dwell; a change to another one-hot value restarts it. The capture fires
  // on the step of d from SETTLE_CYCLES-1 to SETTLE_CYCLES, after which the
  // dwell is parked in HELD so it can never be sampled twice.
  always_comb begin
    state_next = state_reg;
    d_next     = d_reg;
    fire       = 1'b0;
    if (!one_hot) begin
      state_next = ST_IDLE;
      d_next     = '0;
    end else if (changed) begin
      state_next = ST_SETTLE;
      d_next     = '0;
    end else begin
      case (state_reg)
        ST_IDLE, ST_SETTLE: begin
          if (d_reg == DW'(SETTLE_CYCLES - 1)) begin
            fire       = 1'b1;
            state_next = ST_HELD;
            d_next     = DW'(SETTLE_CYCLES);
          end else begin
            state_next = ST_SETTLE;
            d_next     = d_reg + 1'b1;
          end
        end
        ST_HELD: begin
          state_next = ST_HELD;
        end
        default: begin
          state_next = ST_IDLE;
          d_next     = '0;
        end
      endcase
    end
  end

  // Byte lanes with the digit being captured merged in; this is both the
  // next shadow and, when the mask fills, the completed frame.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_lane
      logic hit;
      assign hit                      = fire && (sel_idx == 3'(gi));
      assign shadow_merged[8*gi +: 8] = hit ? cx_q_reg : shadow_reg[8*gi +: 8];
      assign mask_merged[gi]          = mask_reg[gi] | hit;
    end
  endgenerate

  assign frame_done = fire && (mask_merged == 8'hFF);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg          <= ST_IDLE;
      d_reg              <= '0;
      s_reg              <= '0;
      en_q_reg           <= 8'hFF;
      cx_q_reg           <= 8'hFF;
      en_prev_reg        <= 8'hFF;
      mask_reg           <= 8'h00;
      shadow_reg         <= 64'h0;
      frame_reg          <= 64'h0;
      frame_valid_reg    <= 1'b0;
      capture_strobe_reg <= 1'b0;
      capture_idx_reg    <= 3'd0;
      scan_err_reg       <= 1'b0;
    end else begin
      en_q_reg           <= led_en;
      cx_q_reg           <= led_cx;
      en_prev_reg        <= en_q_reg;
      state_reg          <= state_next;
      d_reg              <= d_next;
      capture_strobe_reg <= fire;
      if (fire) capture_idx_reg <= sel_idx;
      shadow_reg         <= shadow_merged;
      mask_reg           <= frame_done ? 8'h00 : mask_merged;
      frame_valid_reg    <= frame_done;
      if (frame_done) frame_reg <= shadow_merged;
      // A new illegal select wins over a simultaneous clear.
      if (illegal) scan_err_reg <= 1'b1;
      else if (err_clr) scan_err_reg <= 1'b0;
      if (frame_done) s_reg <= '0;
      else if (s_reg < SW'(STALE_CYCLES)) s_reg <= s_reg + 1'b1;
    end
  end

  assign frame          = frame_reg;
  assign frame_valid    = frame_valid_reg;
  assign capture_strobe = capture_strobe_reg;
  assign capture_idx    = capture_idx_reg;
  assign scan_err       = scan_err_reg;
  // s is cleared on the edge that raises frame_valid, so stale drops with it.
  assign stale          = (s_reg >= SW'(STALE_CYCLES));

endmodule

// File: tb/tb_seg_scan_capture.sv
// tb_seg_scan_capture
//   Directed bench for seg_scan_capture (SETTLE_CYCLES=16, STALE_CYCLES=100).
//   Stimulus pushes expected captures/frames into queues; a negedge monitor
//   pops and compares them when the DUT strobes.
module tb_seg_scan_capture;

  localparam int SETTLE = 16;
  localparam int STALE  = 100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  led_en = 8'hFF;
  logic [7:0]  led_cx = 8'hFF;
  logic        err_clr = 1'b0;
  logic [63:0] frame;
  logic        frame_valid;
  logic        capture_strobe;
  logic [2:0]  capture_idx;
  logic        scan_err;
  logic        stale;

  seg_scan_capture #(
    .SETTLE_CYCLES(SETTLE),
    .STALE_CYCLES (STALE)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .led_en        (led_en),
    .led_cx        (led_cx),
    .err_clr       (err_clr),
    .frame         (frame),
    .frame_valid   (frame_valid),
    .capture_strobe(capture_strobe),
    .capture_idx   (capture_idx),
    .scan_err      (scan_err),
    .stale         (stale)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [2:0] idx;
    int         due;
  } cap_t;

  cap_t        cap_q[$];
  logic [63:0] frm_q[$];
  logic [63:0] m_shadow = 64'h0;
  logic [7:0]  m_mask = 8'h00;

  int n_checks = 0;
  int n_fails  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Hold one select value for len sampling edges and record what the
  // capture unit should produce for it.
  task automatic dwell(input logic [7:0] en, input logic [7:0] cx, input int len);
    logic [7:0] inv;
    int         k;
    inv    = ~en;
    led_en = en;
    led_cx = cx;
    if ($countones(inv) == 1 && len >= SETTLE + 1) begin
      k = 0;
      for (int i = 0; i < 8; i++) if (inv[i]) k = i;
      cap_q.push_back('{idx: 3'(k), due: cyc + SETTLE + 2});
      m_shadow[8*k +: 8] = cx;
      m_mask[k] = 1'b1;
      if (m_mask == 8'hFF) begin
        frm_q.push_back(m_shadow);
        m_mask = 8'h00;
      end
    end
    repeat (len) step();
  endtask

  task automatic digit(input int i, input logic [7:0] cx, input int len);
    logic [7:0] e;
    e = 8'h01 << i;
    dwell(~e, cx, len);
  endtask

  // Monitor: every strobe must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (capture_strobe) begin
        if (cap_q.size() == 0) begin
          chk("unexpected_capture", capture_strobe, 1'b0);
        end else begin
          cap_t e;
          e = cap_q.pop_front();
          $display("capture idx=%0d cyc=%0d", capture_idx, cyc);
          chk("capture_idx", capture_idx, e.idx);
          chk("capture_cycle", cyc, e.due);
        end
      end
      if (frame_valid) begin
        if (frm_q.size() == 0) begin
          chk("unexpected_frame", frame_valid, 1'b0);
        end else begin
          logic [63:0] ef;
          ef = frm_q.pop_front();
          $display("frame %h cyc=%0d", frame, cyc);
          chk("frame", frame, ef);
          chk("stale_at_frame", stale, 1'b0);
        end
      end
    end
  end

  initial begin
    // Reset and reset-state outputs.
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_frame", frame, 64'h0);
    chk("rst_frame_valid", frame_valid, 1'b0);
    chk("rst_capture_strobe", capture_strobe, 1'b0);
    chk("rst_capture_idx", capture_idx, 3'd0);
    chk("rst_scan_err", scan_err, 1'b0);
    chk("rst_stale", stale, 1'b0);

    // Stale with led_en held blank: asserted exactly from cycle 100.
    repeat (STALE - 1) step();
    chk("stale_before_limit", stale, 1'b0);
    step();
    chk("stale_at_limit", stale, 1'b1);
    repeat (5) step();
    chk("stale_held", stale, 1'b1);

    // In-order scan of all eight digits.
    for (int i = 0; i < 8; i++) digit(i, 8'(8'h10 + i), 40);
    dwell(8'hFF, 8'hFF, 5);
    chk("full_scan_frame", frame, 64'h1716151413121110);
    chk("stale_after_frame", stale, 1'b0);

    // Dwell boundary: 17 cycles is sampled, 16 is not.
    digit(3, 8'h33, 17);
    digit(4, 8'h44, 16);
    dwell(8'hFF, 8'hFF, 20);

    // Digit 5 revisited inside one frame: latest value wins.
    for (int i = 0; i < 5; i++) digit(i, 8'(8'h20 + i), 40);
    digit(5, 8'hC0, 40);
    digit(6, 8'h26, 40);
    digit(5, 8'hF9, 40);
    digit(7, 8'h27, 40);
    dwell(8'hFF, 8'hFF, 5);
    chk("revisit_digit5", frame[47:40], 8'hF9);

    // Illegal select mid-frame: sticky error, assembly continues.
    for (int i = 0; i < 4; i++) digit(i, 8'(8'h40 + i), 40);
    dwell(8'hFC, 8'h00, 1);
    dwell(8'hFF, 8'hFF, 3);
    chk("scan_err_set", scan_err, 1'b1);
    for (int i = 4; i < 8; i++) digit(i, 8'(8'h40 + i), 40);
    dwell(8'hFF, 8'hFF, 5);
    chk("scan_err_held", scan_err, 1'b1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("scan_err_cleared", scan_err, 1'b0);

    // Illegal value and clear in the same cycle: set wins.
    led_en = 8'hFC;
    step();
    led_en = 8'hFF;
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    step();
    chk("scan_err_set_wins", scan_err, 1'b1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("scan_err_cleared2", scan_err, 1'b0);

    // Reset after four digits discards the partial frame.
    for (int i = 0; i < 4; i++) digit(i, 8'(8'h50 + i), 40);
    led_en = 8'hFF;
    led_cx = 8'hFF;
    rst = 1'b1;
    m_shadow = 64'h0;
    m_mask = 8'h00;
    step();
    step();
    rst = 1'b0;
    chk("rst2_frame", frame, 64'h0);
    chk("rst2_capture_strobe", capture_strobe, 1'b0);
    for (int i = 4; i < 8; i++) digit(i, 8'(8'h60 + i), 40);
    dwell(8'hFF, 8'hFF, 5);
    chk("rst2_no_frame", frame, 64'h0);
    for (int i = 0; i < 8; i++) digit(i, 8'(8'h70 + i), 40);
    dwell(8'hFF, 8'hFF, 30);

    chk("captures_drained", cap_q.size(), 0);
    chk("frames_drained", frm_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
